// File: rtl/psram_xfer_pkg.sv
// psram_xfer_pkg: shared types and widths for the psram transfer scheduler
package psram_xfer_pkg;
  localparam int PSRAM_XFER_ADDR_W = 32;
  localparam int PSRAM_XFER_DATA_W = 64;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} psram_xfer_state_e;
  typedef struct packed {
    logic                         cfg;
    logic                         rdwr;
    logic [PSRAM_XFER_ADDR_W-1:0] addr;
    logic [PSRAM_XFER_DATA_W-1:0] wdata;
    logic [7:0]                   bm;
  } psram_xfer_req_t;
endpackage

// File: rtl/psram_req_fifo.sv
// psram_req_fifo: synchronous FIFO of bus transfer requests
module psram_req_fifo
  import psram_xfer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            push,
  input  psram_xfer_req_t din,
  input  logic            pop,
  output psram_xfer_req_t dout,
  output logic            full,
  output logic            empty
);
  localparam int AW = $clog2(DEPTH);
  psram_xfer_req_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout  = mem[rd_ptr];
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/psram_xfer_arb.sv
// psram_xfer_arb: schedules bus and cfg transfers onto psram_core, one outstanding at a time
module psram_xfer_arb
  import psram_xfer_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         cfg_cflg_i,
  input  logic                         cfg_req_i,
  input  logic                         cfg_rdwr_i,
  output logic                         cfg_ack_o,
  output logic                         cfg_busy_o,
  input  logic                         bus_req_valid_i,
  output logic                         bus_req_ready_o,
  input  logic                         bus_req_wen_i,
  input  logic [PSRAM_XFER_ADDR_W-1:0] bus_req_addr_i,
  input  logic [PSRAM_XFER_DATA_W-1:0] bus_req_wdata_i,
  input  logic [7:0]                   bus_req_bm_i,
  output logic                         bus_rsp_valid_o,
  input  logic                         bus_rsp_ready_i,
  output logic [PSRAM_XFER_DATA_W-1:0] bus_rsp_rdata_o,
  output logic                         bus_rsp_err_o,
  output logic                         xfer_valid_o,
  input  logic                         xfer_ready_i,
  output logic                         xfer_cfg_o,
  output logic                         xfer_rdwr_o,
  output logic [PSRAM_XFER_ADDR_W-1:0] xfer_addr_o,
  output logic [PSRAM_XFER_DATA_W-1:0] xfer_wdata_o,
  output logic [7:0]                   xfer_bm_o,
  input  logic                         xfer_done_i,
  input  logic [PSRAM_XFER_DATA_W-1:0] xfer_rdata_i
);
  localparam int TW = $clog2(TIMEOUT_CYC);
  psram_xfer_state_e state, state_nx;
  psram_xfer_req_t cur, fifo_dout, bus_entry;
  logic fifo_full, fifo_empty, push, issue_cfg, issue_bus, drop_cfg, timeout;
  logic cfg_pend, cfg_pend_rdwr, err;
  logic [TW-1:0] timer;
  logic [PSRAM_XFER_DATA_W-1:0] rdata;
  assign bus_entry = '{cfg: 1'b0, rdwr: ~bus_req_wen_i, addr: bus_req_addr_i,
                       wdata: bus_req_wdata_i, bm: bus_req_bm_i};
  assign bus_req_ready_o = ~fifo_full;
  assign push = bus_req_valid_i & ~fifo_full;
  psram_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push    (push),
    .din     (bus_entry),
    .pop     (issue_bus),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );
  // cfg mode gates bus traffic entirely; a cfg request outside cfg mode is dropped
  assign issue_cfg = state == IDLE && cfg_pend && cfg_cflg_i;
  assign issue_bus = state == IDLE && !fifo_empty && !cfg_cflg_i;
  assign drop_cfg  = state == IDLE && cfg_pend && !cfg_cflg_i;
  assign timeout   = timer == TW'(TIMEOUT_CYC - 1);
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = (issue_cfg || issue_bus) ? ISSUE : IDLE;
      ISSUE:   state_nx = xfer_ready_i ? WAIT : ISSUE;
      WAIT:    state_nx = (xfer_done_i || timeout) ? RESP : WAIT;
      RESP:    state_nx = (cur.cfg || bus_rsp_ready_i) ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state         <= IDLE;
      cur           <= '0;
      cfg_pend      <= 1'b0;
      cfg_pend_rdwr <= 1'b0;
      timer         <= '0;
      rdata         <= '0;
      err           <= 1'b0;
    end else begin
      state <= state_nx;
      if (cfg_req_i && !cfg_busy_o) begin
        cfg_pend      <= 1'b1;
        cfg_pend_rdwr <= cfg_rdwr_i;
      end else if (issue_cfg || drop_cfg) cfg_pend <= 1'b0;
      if (issue_cfg) cur <= '{cfg: 1'b1, rdwr: cfg_pend_rdwr, addr: '0, wdata: '0, bm: '0};
      else if (issue_bus) cur <= fifo_dout;
      timer <= state == WAIT ? timer + 1'b1 : '0;
      // done has priority over a coincident timeout
      if (state == WAIT && xfer_done_i) begin
        rdata <= cur.rdwr ? xfer_rdata_i : '0;
        err   <= 1'b0;
      end else if (state == WAIT && timeout) begin
        rdata <= '0;
        err   <= 1'b1;
      end
    end
  end
  assign cfg_busy_o      = cfg_pend | (state != IDLE && cur.cfg);
  assign cfg_ack_o       = state == RESP && cur.cfg;
  assign bus_rsp_valid_o = state == RESP && !cur.cfg;
  assign bus_rsp_rdata_o = rdata;
  assign bus_rsp_err_o   = err;
  assign xfer_valid_o    = state == ISSUE;
  assign xfer_cfg_o      = cur.cfg;
  assign xfer_rdwr_o     = cur.rdwr;
  assign xfer_addr_o     = cur.addr;
  assign xfer_wdata_o    = cur.wdata;
  assign xfer_bm_o       = cur.bm;
endmodule

// File: tb/tb_psram_xfer_arb.sv
// tb_psram_xfer_arb: scoreboard bench for psram_xfer_arb with a behavioural core model
module tb_psram_xfer_arb;
  import psram_xfer_pkg::*;
  localparam int TMO = 16;
  typedef struct packed {logic [63:0] rdata; logic err;} rsp_t;
  logic clk_i = 0, rst_n_i = 0;
  logic cfg_cflg_i = 0, cfg_req_i = 0, cfg_rdwr_i = 0, cfg_ack_o, cfg_busy_o;
  logic bus_req_valid_i = 0, bus_req_ready_o, bus_req_wen_i = 0;
  logic [31:0] bus_req_addr_i = 0;
  logic [63:0] bus_req_wdata_i = 0;
  logic [7:0] bus_req_bm_i = 0;
  logic bus_rsp_valid_o, bus_rsp_ready_i = 0, bus_rsp_err_o;
  logic [63:0] bus_rsp_rdata_o;
  logic xfer_valid_o, xfer_ready_i = 0, xfer_cfg_o, xfer_rdwr_o, xfer_done_i;
  logic [31:0] xfer_addr_o;
  logic [63:0] xfer_wdata_o, xfer_rdata_i = 0;
  logic [7:0] xfer_bm_o;
  logic core_done = 0, force_done = 0;
  psram_xfer_req_t exp_x[$];
  rsp_t exp_r[$];
  int checks = 0, errors = 0, cyc = 0, outstanding = 0, ack_cnt = 0, hs_cyc = 0;
  int rdy_dly = 1, done_dly = 10, rsp_hold = 0;
  bit hang = 0, tmo_mode = 0, rsp_prev = 0, ack_prev = 0;
  logic [31:0] core_a;
  logic core_rd;
  assign xfer_done_i = core_done | force_done;
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;
  psram_xfer_arb #(.FIFO_DEPTH(4), .TIMEOUT_CYC(TMO)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .cfg_cflg_i(cfg_cflg_i), .cfg_req_i(cfg_req_i), .cfg_rdwr_i(cfg_rdwr_i),
    .cfg_ack_o(cfg_ack_o), .cfg_busy_o(cfg_busy_o),
    .bus_req_valid_i(bus_req_valid_i), .bus_req_ready_o(bus_req_ready_o),
    .bus_req_wen_i(bus_req_wen_i), .bus_req_addr_i(bus_req_addr_i),
    .bus_req_wdata_i(bus_req_wdata_i), .bus_req_bm_i(bus_req_bm_i),
    .bus_rsp_valid_o(bus_rsp_valid_o), .bus_rsp_ready_i(bus_rsp_ready_i),
    .bus_rsp_rdata_o(bus_rsp_rdata_o), .bus_rsp_err_o(bus_rsp_err_o),
    .xfer_valid_o(xfer_valid_o), .xfer_ready_i(xfer_ready_i), .xfer_cfg_o(xfer_cfg_o),
    .xfer_rdwr_o(xfer_rdwr_o), .xfer_addr_o(xfer_addr_o), .xfer_wdata_o(xfer_wdata_o),
    .xfer_bm_o(xfer_bm_o), .xfer_done_i(xfer_done_i), .xfer_rdata_i(xfer_rdata_i)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // core model: accepts after rdy_dly cycles, completes done_dly cycles after the handshake
  initial forever begin
    @(posedge clk_i); #1;
    if (xfer_valid_o && rst_n_i) begin
      repeat (rdy_dly) begin @(posedge clk_i); #1; end
      xfer_ready_i = 1; core_a = xfer_addr_o; core_rd = xfer_rdwr_o;
      @(posedge clk_i); #1;
      xfer_ready_i = 0;
      if (!hang) begin
        repeat (done_dly - 1) begin @(posedge clk_i); #1; end
        core_done = 1;
        xfer_rdata_i = core_rd ? {32'h0, core_a} + 64'hA5 : 64'hDEAD_BEEF;
        @(posedge clk_i); #1;
        core_done = 0;
      end
    end
  end
  initial forever begin
    @(posedge clk_i); #1;
    if (bus_rsp_valid_o) begin
      repeat (rsp_hold) begin @(posedge clk_i); #1; end
      bus_rsp_ready_i = 1;
      @(posedge clk_i); #1;
      bus_rsp_ready_i = 0;
    end
  end
  always @(negedge clk_i) begin
    psram_xfer_req_t e;
    if (!rst_n_i) begin
      outstanding = 0;
      exp_r.delete();
    end else begin
      if (xfer_valid_o && xfer_ready_i) begin
        chk("single_outstanding", 64'(outstanding), 0);
        outstanding++;
        hs_cyc = cyc + 1;
        if (exp_x.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_xfer: got addr %h expected none", xfer_addr_o);
        end else begin
          e = exp_x.pop_front();
          chk("xfer_cfg", 64'(xfer_cfg_o), 64'(e.cfg));
          chk("xfer_rdwr", 64'(xfer_rdwr_o), 64'(e.rdwr));
          chk("xfer_addr", 64'(xfer_addr_o), 64'(e.addr));
          chk("xfer_wdata", xfer_wdata_o, e.wdata);
          chk("xfer_bm", 64'(xfer_bm_o), 64'(e.bm));
        end
      end
      if (bus_rsp_valid_o) begin
        if (!rsp_prev && tmo_mode) chk("timeout_latency", 64'(cyc - hs_cyc), TMO);
        if (exp_r.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp: got rdata %h expected none", bus_rsp_rdata_o);
        end else begin
          chk("rsp_rdata", bus_rsp_rdata_o, exp_r[0].rdata);
          chk("rsp_err", 64'(bus_rsp_err_o), 64'(exp_r[0].err));
          if (bus_rsp_ready_i) begin
            void'(exp_r.pop_front());
            outstanding--;
          end
        end
      end
      if (cfg_ack_o) begin
        chk("cfg_ack_pulse", 64'(ack_prev), 0);
        ack_cnt++;
        outstanding--;
      end
    end
    rsp_prev = bus_rsp_valid_o;
    ack_prev = cfg_ack_o;
  end
  // mode: 0 untracked, 1 normal completion, 2 timeout completion
  task automatic push(input logic wen, input logic [31:0] addr, input logic [63:0] wdata,
                      input logic [7:0] bm, input int mode);
    int n = 0;
    bit ok;
    bus_req_valid_i = 1; bus_req_wen_i = wen; bus_req_addr_i = addr;
    bus_req_wdata_i = wdata; bus_req_bm_i = bm;
    if (mode != 0) begin
      exp_x.push_back('{cfg: 1'b0, rdwr: ~wen, addr: addr, wdata: wdata, bm: bm});
      if (mode == 2) exp_r.push_back('{rdata: 64'h0, err: 1'b1});
      else exp_r.push_back('{rdata: wen ? 64'h0 : {32'h0, addr} + 64'hA5, err: 1'b0});
    end
    do begin
      ok = bus_req_ready_o;
      @(posedge clk_i); #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) begin
      checks++; errors++;
      $display("FAIL push_accept: got ready 0 expected 1 within 200 cycles");
    end
    bus_req_valid_i = 0;
  endtask
  task automatic drain(input int bound);
    int n = 0;
    while ((exp_r.size() != 0 || exp_x.size() != 0 || outstanding != 0) && n < bound) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk("drain_done", 64'(n < bound), 1);
  endtask
  task automatic chk_reset_outputs();
    chk("rst_req_ready", 64'(bus_req_ready_o), 1);
    chk("rst_xfer_valid", 64'(xfer_valid_o), 0);
    chk("rst_rsp_valid", 64'(bus_rsp_valid_o), 0);
    chk("rst_rsp_rdata", bus_rsp_rdata_o, 0);
    chk("rst_rsp_err", 64'(bus_rsp_err_o), 0);
    chk("rst_cfg_ack", 64'(cfg_ack_o), 0);
    chk("rst_cfg_busy", 64'(cfg_busy_o), 0);
    chk("rst_xfer_addr", 64'(xfer_addr_o), 0);
    chk("rst_xfer_cfg", 64'(xfer_cfg_o), 0);
    chk("rst_fifo_count", 64'(dut.u_fifo.count), 0);
  endtask
  initial begin
    int ack0, n;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk_reset_outputs();
    @(posedge clk_i); #1;
    rst_n_i = 1;
    @(posedge clk_i); #1;
    push(1, 32'h100, 64'h1122334455667788, 8'hFF, 1);
    @(negedge clk_i); chk("issue_lat_c1", 64'(xfer_valid_o), 0);
    @(negedge clk_i); chk("issue_lat_c2", 64'(xfer_valid_o), 1);
    drain(100);
    rsp_hold = 5; cfg_cflg_i = 1;
    for (int i = 0; i < 4; i++) push(0, 32'(i * 8), 64'h0, 8'hFF, 1);
    @(negedge clk_i);
    chk("full_count", 64'(dut.u_fifo.count), 4);
    chk("full_ready", 64'(bus_req_ready_o), 0);
    fork
      push(0, 32'h20, 64'h0, 8'hFF, 1);
      begin
        repeat (2) begin @(negedge clk_i); chk("fifth_stall", 64'(bus_req_ready_o), 0); end
        @(posedge clk_i); #1;
        cfg_cflg_i = 0;
      end
    join
    @(negedge clk_i); chk("refill_count", 64'(dut.u_fifo.count), 4);
    drain(500);
    rsp_hold = 0; cfg_cflg_i = 1;
    push(1, 32'h300, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F, 1);
    push(1, 32'h308, 64'h0123_4567_89AB_CDEF, 8'hF0, 1);
    exp_x.push_front('{cfg: 1'b1, rdwr: 1'b1, addr: 32'h0, wdata: 64'h0, bm: 8'h0});
    ack0 = ack_cnt;
    cfg_rdwr_i = 1; cfg_req_i = 1;
    @(posedge clk_i); #1;
    cfg_req_i = 0; cfg_rdwr_i = 0;
    @(negedge clk_i); chk("cfg_busy_set", 64'(cfg_busy_o), 1);
    repeat (3) @(posedge clk_i); #1;
    cfg_req_i = 1;
    @(posedge clk_i); #1;
    cfg_req_i = 0;
    n = 0;
    while (ack_cnt == ack0 && n < 100) begin @(posedge clk_i); #1; n++; end
    repeat (10) @(posedge clk_i);
    @(negedge clk_i);
    chk("cfg_ack_count", 64'(ack_cnt - ack0), 1);
    chk("cfg_busy_clear", 64'(cfg_busy_o), 0);
    chk("cfg_blocks_bus", 64'(xfer_valid_o), 0);
    chk("cfg_fifo_held", 64'(dut.u_fifo.count), 2);
    @(posedge clk_i); #1;
    cfg_cflg_i = 0;
    drain(200);
    hang = 1; tmo_mode = 1;
    push(0, 32'h200, 64'h0, 8'hFF, 2);
    drain(100);
    hang = 0; tmo_mode = 0;
    push(0, 32'h208, 64'h0, 8'hFF, 1);
    drain(100);
    for (int i = 0; i < 10; i++)
      push(i[0], 32'h1000 + 32'(i * 8), {8{8'(i + 1)}}, 8'(1 << (i % 8)), 1);
    drain(1000);
    hang = 1;
    push(0, 32'h400, 64'h0, 8'hFF, 1);
    n = 0;
    while (outstanding == 0 && n < 50) begin @(negedge clk_i); n++; end
    chk("reach_wait", 64'(outstanding), 1);
    push(1, 32'h408, 64'h5555, 8'hFF, 0);
    rst_n_i = 0;
    @(posedge clk_i);
    @(negedge clk_i);
    chk_reset_outputs();
    @(posedge clk_i); #1;
    rst_n_i = 1; hang = 0;
    force_done = 1; xfer_rdata_i = 64'h1234;
    @(posedge clk_i); #1;
    force_done = 0;
    repeat (4) begin
      @(negedge clk_i);
      chk("late_done_rsp", 64'(bus_rsp_valid_o), 0);
      chk("late_done_xfer", 64'(xfer_valid_o), 0);
    end
    chk("post_rst_fifo", 64'(dut.u_fifo.count), 0);
    @(posedge clk_i); #1;
    push(0, 32'h500, 64'h0, 8'hFF, 1);
    drain(100);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end
endmodule
